alu_arbiter: RTL



---
 rtl/alu_arbiter_pkg.sv | 16 +
 rtl/alu_arbiter_alu.sv | 38 +++
 rtl/alu_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: the default data width and
// the RV32I funct3 encodings understood by the shared ALU.
package alu_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_ADD  = 3'b000;  // ADD / SUB
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;  // SRL / SRA
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational RV32I integer ALU. funct7[5] arrives as 'mod'; 'immediate'
// marks I-type forms, where funct7[5] selects SRAI but never a subtract.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic            mod,
    input  logic            immediate,
    input  logic [XLEN-1:0] val1,
    input  logic [XLEN-1:0] val2,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = val2[4:0];

    // Select the operation named by funct3; arithmetic wraps at XLEN bits.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, so no path leaves it unassigned and no latch is inferred.
        result = '0;
        case (funct3)
            F3_ADD:  result = (mod && !immediate) ? (val1 - val2) : (val1 + val2);
            F3_SLL:  result = val1 << shamt;
            F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(val1) < $signed(val2))};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, (val1 < val2)};
            F3_XOR:  result = val1 ^ val2;
            F3_SRL:  result = mod ? XLEN'($signed(val1) >>> shamt) : (val1 >> shamt);
            F3_OR:   result = val1 | val2;
            F3_AND:  result = val1 & val2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NREQ requesters. One request is
// granted per cycle; its result lands in a single registered response slot
// one cycle later, tagged with the requester index.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_funct3,
    input  logic [NREQ-1:0]      req_mod,
    input  logic [NREQ-1:0]      req_imm,
    input  logic [XLEN*NREQ-1:0] req_val1,
    input  logic [XLEN*NREQ-1:0] req_val2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_result
);

    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            slot_free;

    logic [2:0]      alu_funct3;
    logic            alu_mod;
    logic            alu_imm;
    logic [XLEN-1:0] alu_val1;
    logic [XLEN-1:0] alu_val2;
    logic [XLEN-1:0] alu_result;

    // The slot can take a new result if it is empty or being drained now.
    assign slot_free = !rsp_valid || rsp_ready;

    // Round-robin pick: scan from last_grant+1 upward with wrap; reset and a
    // blocked slot suppress every grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = last_grant;
        if (!rst && slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
                for (int i = 0; i < NREQ; i++) begin
                    if (!grant_any && cand == IDW'(i) && req_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = IDW'(i);
                    end
                end
            end
        end
    end

    // One-hot ready and ALU operand mux from the granted slice; zeros when idle.
    always_comb begin
        req_ready  = '0;
        alu_funct3 = '0;
        alu_mod    = 1'b0;
        alu_imm    = 1'b0;
        alu_val1   = '0;
        alu_val2   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && grant_idx == IDW'(i)) begin
                req_ready[i] = 1'b1;
                alu_funct3   = req_funct3[3*i +: 3];
                alu_mod      = req_mod[i];
                alu_imm      = req_imm[i];
                alu_val1     = req_val1[XLEN*i +: XLEN];
                alu_val2     = req_val2[XLEN*i +: XLEN];
            end
        end
    end

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3   (alu_funct3),
        .mod      (alu_mod),
        .immediate(alu_imm),
        .val1     (alu_val1),
        .val2     (alu_val2),
        .result   (alu_result)
    );

    // Response slot and arbitration pointer: a grant fills the slot (even
    // while it drains), otherwise a drain empties it and data is kept.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (grant_any) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_result <= alu_result;
            last_grant <= grant_idx;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
